// File: rtl/sam_stream_sink_if.sv
// Ready/valid token stream between a transmitter (master) and sam_stream_sink (slave).
interface sam_stream_sink_if #(
    parameter int DATA_W = 17
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sam_stream_sink.sv
// Token stream sink: classifies, counts and captures tokens; rd_data has 1-cycle latency.
// ready is registered from next state and bp_mode source; SINK_PROTOCOL_CHECK_EN adds sticky proto_err.
module sam_stream_sink #(
    parameter int                DATA_W     = 17,
    parameter int                DEPTH      = 64,
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
    parameter logic [DATA_W-1:0] DONE_TOKEN = 17'h10100,
    localparam int               ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    sam_stream_sink_if.slave  s,
    input  logic [1:0]        bp_mode,
    input  logic [3:0]        bp_period,
    output logic              done,
    output logic [15:0]       token_count,
    output logic [15:0]       stop_count,
    output logic [31:0]       cycle_count,
    output logic              overflow,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef SINK_PROTOCOL_CHECK_EN
    ,
    output logic              proto_err
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [15:0]       lfsr, lfsr_nxt;
    logic [3:0]        per_cnt, per_cnt_nxt;
    logic              bp_rdy, ready_nxt;
    logic              clr, accept, tok_done, tok_stop, buf_full;
    logic [ADDR_W:0]   wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign clr      = !rst_n || flush;
    assign buf_full = (wr_ptr == PTR_FULL);
    assign done     = (state == ST_DONE);

    always_comb begin
        accept    = s.valid && s.ready && clk_en && !clr && (state != ST_DONE);
        tok_done  = (s.data == DONE_TOKEN);
        tok_stop  = s.data[DATA_W-1] && (s.data[9:8] == 2'b00) && !tok_done;
        state_nxt = state;
        case (state)
            ST_IDLE: if (s.valid) state_nxt = (accept && tok_done) ? ST_DONE : ST_RUN;
            ST_RUN:  if (accept && tok_done) state_nxt = ST_DONE;
            default: state_nxt = state;
        endcase

        // LFSR freezes once the stream has completed
        lfsr_nxt    = (state == ST_DONE) ? lfsr
                    : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        per_cnt_nxt = (per_cnt >= bp_period) ? 4'd0 : per_cnt + 4'd1;
        case (bp_mode)
            2'd0:    bp_rdy = 1'b1;
            2'd1:    bp_rdy = lfsr_nxt[0];
            2'd2:    bp_rdy = (per_cnt_nxt == 4'd0);
            default: bp_rdy = 1'b0;
        endcase
        ready_nxt = bp_rdy && (state_nxt != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            s.ready     <= 1'b0;
            lfsr        <= LFSR_SEED;
            per_cnt     <= 4'd0;
            wr_ptr      <= '0;
            token_count <= 16'd0;
            stop_count  <= 16'd0;
            cycle_count <= 32'd0;
            overflow    <= 1'b0;
            rd_data     <= '0;
        end else if (clk_en) begin
            state   <= state_nxt;
            s.ready <= ready_nxt;
            lfsr    <= lfsr_nxt;
            per_cnt <= per_cnt_nxt;
            rd_data <= mem[rd_addr];

            if (state == ST_IDLE && s.valid)
                cycle_count <= 32'd1;
            else if (state == ST_RUN && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;

            if (accept) begin
                if (token_count != 16'hFFFF)
                    token_count <= token_count + 16'd1;
                if (tok_stop && stop_count != 16'hFFFF)
                    stop_count <= stop_count + 16'd1;
                // a full buffer drops the payload but the token still counts
                if (buf_full)
                    overflow <= 1'b1;
                else
                    wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !buf_full)
            mem[wr_ptr[ADDR_W-1:0]] <= s.data;
    end

`ifdef SINK_PROTOCOL_CHECK_EN
    logic              pend;
    logic [DATA_W-1:0] pend_data;

    always_ff @(posedge clk) begin
        if (clr) begin
            pend      <= 1'b0;
            pend_data <= '0;
            proto_err <= 1'b0;
        end else if (clk_en) begin
            pend      <= s.valid && !s.ready;
            pend_data <= s.data;
            if ((pend && (!s.valid || s.data != pend_data)) || (s.valid && state == ST_DONE))
                proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sam_stream_sink.sv
// Directed bench for sam_stream_sink; readback expectations flow through a scoreboard queue.
module tb_sam_stream_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  bp_mode = 2'd0;
    logic [3:0]  bp_period = 4'd0;
    logic        done;
    logic [15:0] token_count;
    logic [15:0] stop_count;
    logic [31:0] cycle_count;
    logic        overflow;
    logic [5:0]  rd_addr = 6'd0;
    logic [16:0] rd_data;
`ifdef SINK_PROTOCOL_CHECK_EN
    logic        proto_err;
`endif

    sam_stream_sink_if #(.DATA_W(17)) s_if ();

    sam_stream_sink dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .flush       (flush),
        .s           (s_if),
        .bp_mode     (bp_mode),
        .bp_period   (bp_period),
        .done        (done),
        .token_count (token_count),
        .stop_count  (stop_count),
        .cycle_count (cycle_count),
        .overflow    (overflow),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef SINK_PROTOCOL_CHECK_EN
        ,
        .proto_err   (proto_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [16:0] rd_exp_q[$];
    logic        rd_req = 1'b0;
    logic        rd_chk = 1'b0;
    logic [15:0] lfsr_m;

    // readback monitor: rd_data is valid one edge after the address was presented
    always @(posedge clk) rd_chk <= rd_req;

    always @(negedge clk) begin
        logic [16:0] exp;
        if (rd_chk) begin
            n_chk++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL readback_unexpected: rd_data=%0h with no expected entry", rd_data);
            end else begin
                exp = rd_exp_q.pop_front();
                if (rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL readback: rd_data=%0h expected %0h", rd_data, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [3:0] p);
        rst_n       = 1'b0;
        flush       = 1'b0;
        clk_en      = 1'b1;
        s_if.valid  = 1'b0;
        s_if.data   = 17'd0;
        bp_mode     = m;
        bp_period   = p;
        rd_req      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (s_if.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready_timeout: ready=%0b required 1", s_if.ready);
        end
    endtask

    task automatic send(input logic [16:0] t);
        int n = 0;
        s_if.data  = t;
        s_if.valid = 1'b1;
        while (s_if.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: token %0h not accepted, ready=%0b", t, s_if.ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic readback(input int a, input logic [16:0] exp);
        rd_addr = 6'(a);
        rd_req  = 1'b1;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        int rdy_hi;
        s_if.valid = 1'b0;
        s_if.data  = 17'd0;

        // reset state
        do_reset(2'd0, 4'd0);
        chk("rst_ready",       32'(s_if.ready),  32'd0);
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_token_count", 32'(token_count), 32'd0);
        chk("rst_stop_count",  32'(stop_count),  32'd0);
        chk("rst_cycle_count", cycle_count,      32'd0);
        chk("rst_overflow",    32'(overflow),    32'd0);
        chk("rst_rd_data",     32'(rd_data),     32'd0);

        // always-ready stream with a stop and a done token
        wait_ready();
        send(17'd5);
        send(17'd6);
        send(17'd7);
        send(17'h10000);
        chk("t1_done_before_last", 32'(done), 32'd0);
        send(17'h10100);
        s_if.valid = 1'b0;
        chk("t1_token_count", 32'(token_count), 32'd5);
        chk("t1_stop_count",  32'(stop_count),  32'd1);
        chk("t1_cycle_count", cycle_count,      32'd5);
        chk("t1_done",        32'(done),        32'd1);
        chk("t1_ready_in_done", 32'(s_if.ready), 32'd0);
        s_if.data  = 17'd9;
        s_if.valid = 1'b1;
        repeat (3) @(negedge clk);
        s_if.valid = 1'b0;
        chk("t1_frozen_tokens", 32'(token_count), 32'd5);
        chk("t1_frozen_cycles", cycle_count,      32'd5);
        readback(0, 17'd5);
        readback(1, 17'd6);
        readback(2, 17'd7);
        readback(3, 17'h10000);
        readback(4, 17'h10100);

        // periodic backpressure, ready one cycle in four
        do_reset(2'd2, 4'd3);
        wait_ready();
        send(17'h11);
        chk("t2_ready_low_after_accept", 32'(s_if.ready), 32'd0);
        send(17'h12);
        send(17'h13);
        send(17'h10100);
        s_if.valid = 1'b0;
        chk("t2_token_count", 32'(token_count), 32'd4);
        chk("t2_cycle_count", cycle_count,      32'd13);
        chk("t2_done",        32'(done),        32'd1);
        readback(0, 17'h11);
        readback(1, 17'h12);
        readback(2, 17'h13);
        readback(3, 17'h10100);

        // capture buffer overflow
        do_reset(2'd0, 4'd0);
        wait_ready();
        for (int i = 1; i <= 70; i++) begin
            send(17'(i));
            if (i == 64) chk("t3_overflow_at_full", 32'(overflow), 32'd0);
            if (i == 65) chk("t3_overflow_past_full", 32'(overflow), 32'd1);
        end
        send(17'h10100);
        s_if.valid = 1'b0;
        chk("t3_token_count", 32'(token_count), 32'd71);
        chk("t3_overflow",    32'(overflow),    32'd1);
        chk("t3_done",        32'(done),        32'd1);
        chk("t3_cycle_count", cycle_count,      32'd71);
        readback(63, 17'd64);
        readback(0,  17'd1);

        // flush mid-stream, then a fresh stream
        do_reset(2'd0, 4'd0);
        wait_ready();
        send(17'h21);
        send(17'h22);
        send(17'h23);
        s_if.data = 17'h24;
        flush     = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        s_if.valid = 1'b0;
        chk("t4_flush_tokens", 32'(token_count), 32'd0);
        chk("t4_flush_cycles", cycle_count,      32'd0);
        chk("t4_flush_ready",  32'(s_if.ready),  32'd0);
        wait_ready();
        send(17'h10200);
        send(17'h10001);
        send(17'h10100);
        s_if.valid = 1'b0;
        chk("t4_token_count", 32'(token_count), 32'd3);
        chk("t4_stop_count",  32'(stop_count),  32'd1);
        chk("t4_cycle_count", cycle_count,      32'd3);
        chk("t4_done",        32'(done),        32'd1);
        readback(0, 17'h10200);
        readback(1, 17'h10001);
        readback(2, 17'h10100);

        // never ready, then clock-enable hold
        do_reset(2'd3, 4'd0);
        s_if.data  = 17'h55;
        s_if.valid = 1'b1;
        rdy_hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (s_if.ready === 1'b1) rdy_hi++;
        end
        chk("t5_ready_high_count", 32'(rdy_hi), 32'd0);
        chk("t5_cycle_count", cycle_count,      32'd100);
        chk("t5_token_count", 32'(token_count), 32'd0);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_clk_en_hold", cycle_count, 32'd100);
        clk_en = 1'b1;
        @(negedge clk);
        chk("t5_clk_en_resume", cycle_count, 32'd101);
        s_if.valid = 1'b0;

        // LFSR backpressure: ready follows bit 0 of the advancing LFSR
        do_reset(2'd1, 4'd0);
        lfsr_m = 16'hACE1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            chk("t6_lfsr_ready", 32'(s_if.ready), 32'(lfsr_m[0]));
        end
        send(17'h31);
        send(17'h32);
        send(17'h33);
        send(17'h10100);
        s_if.valid = 1'b0;
        chk("t6_token_count", 32'(token_count), 32'd4);
        chk("t6_done",        32'(done),        32'd1);
        readback(0, 17'h31);
        readback(2, 17'h33);

`ifdef SINK_PROTOCOL_CHECK_EN
        do_reset(2'd3, 4'd0);
        s_if.data  = 17'h40;
        s_if.valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_proto_clean", 32'(proto_err), 32'd0);
        s_if.valid = 1'b0;
        @(negedge clk);
        chk("t7_proto_withdraw", 32'(proto_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("t7_proto_sticky", 32'(proto_err), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t7_proto_flush", 32'(proto_err), 32'd0);
        do_reset(2'd0, 4'd0);
        wait_ready();
        send(17'h10100);
        chk("t7_proto_at_done", 32'(proto_err), 32'd0);
        @(negedge clk);
        chk("t7_proto_valid_in_done", 32'(proto_err), 32'd1);
        s_if.valid = 1'b0;
`endif

        @(negedge clk);
        chk("readback_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sam_stream_sink.md
Name: sam_stream_sink

Overview:
- Synthesizable receiving end of the 17-bit ready/valid token stream used between GLB tiles and fiber_access/read-scanner outputs.
- Consumes tokens under programmable backpressure and classifies them as data, stop or done.
- Captures every accepted token into a readback buffer and reports token and cycle statistics.
- Used as the hardware sink for on-chip sparse-stream self-test, mirroring the GLB-side transmitter.

Parameters:
- DATA_W, 17, token width; bit DATA_W-1 is the control flag.
- DEPTH, 64, capture-buffer entries; power of two.
- LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR; must be nonzero.
- DONE_TOKEN, 17'h10100, done encoding.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clk_en  in  1  global clock enable; when 0 all state holds
- flush  in  1  synchronous clear, same effect as reset except cfg inputs
- data  in  DATA_W  token from transmitter
- valid  in  1  token valid
- ready  out  1  sink ready
- bp_mode  in  2  0=always ready, 1=LFSR bit0, 2=ready one cycle in every (bp_period+1), 3=never ready
- bp_period  in  4  period for bp_mode 2
- done  out  1  done token accepted; sticky
- token_count  out  16  accepted tokens, including done
- stop_count  out  16  accepted stop tokens
- cycle_count  out  32  cycles from first valid to done handshake, inclusive
- overflow  out  1  sticky; a token arrived while the buffer was full
- rd_addr  in  log2(DEPTH)  readback address
- rd_data  out  DATA_W  buffer[rd_addr], registered, 1-cycle latency

Behaviour:
- Reset (rst_n=0 at posedge, ignores clk_en) or flush=1 clears everything:
  - ready=0, done=0, all counters 0, overflow=0, wr_ptr=0, rd_data=0.
  - LFSR=LFSR_SEED, state=IDLE, period counter=0.
- Token classes:
  - done: data==DONE_TOKEN.
  - stop: bit16=1, bits[9:8]=2'b00, not done.
  - data: bit16=0.
  - other control: bit16=1 and neither done nor stop; counted in token_count only.
- Handshake: a token is accepted on a posedge where valid&ready&clk_en. ready is registered, computed from next state and the backpressure source. There is no combinational path from valid to ready.
- Backpressure:
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11; advances every clk_en cycle in all states except DONE.
  - Mode 2: counter counts 0..bp_period; ready is high when the counter is 0.
- FSM:
  - IDLE: ready per bp_mode. The first cycle with valid=1 starts cycle_count at 1 and moves to RUN; if that cycle also handshakes, the token is processed normally.
  - RUN: cycle_count increments every clk_en cycle. An accepted done token moves to DONE.
  - DONE: ready=0, done=1, counters frozen. Only reset or flush leaves DONE. Further valid is ignored.
  - A first-valid cycle that also accepts the done token goes IDLE->DONE with cycle_count=1.
- Capture:
  - Each accepted token is written to buffer[wr_ptr] and wr_ptr increments.
  - When wr_ptr==DEPTH the token is not stored, overflow sets, and token_count/stop_count still increment.
  - wr_ptr does not wrap.
- Counters saturate at all-ones and do not wrap.
- Readback: rd_data <= buffer[rd_addr] each clk_en cycle. Same-cycle write and read to the same address returns the old value.
- Reset or flush asserted mid-stream drops the current token; no handshake occurs in that cycle.

Optional Feature:
- Macro SINK_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output proto_err (1, sticky, reset 0).
  - Sets when a pending token is withdrawn or altered: valid was 1 and ready 0 last cycle, and this cycle valid falls or data changes.
  - Also sets when valid is high in DONE.
- Undefined: no proto_err port and no related logic.

Test Plan:
- bp_mode=0; send 5,6,7,0x10000 (stop), 0x10100 with valid continuous -> token_count=5, stop_count=1, cycle_count=5, done=1 at cycle 6. rd_addr 0..4 reads 5,6,7,0x10000,0x10100.
- bp_mode=2, bp_period=3; 3 tokens then done -> ready high 1 cycle in 4. All 4 tokens accepted in order, cycle_count=13 with transmitter valid from cycle 1.
- DEPTH=64; send 70 data tokens + done -> overflow=1, token_count=71, buffer[63] holds token 64.
- Flush asserted mid-stream after 3 tokens, then resend 2+done -> token_count=3, buffer[0..2] holds new tokens, done=1.
- bp_mode=3 with valid high for 100 cycles -> no acceptance, ready=0, cycle_count=100, token_count=0.
- With SINK_PROTOCOL_CHECK_EN: drop valid while ready=0 -> proto_err=1 next cycle and held until flush.
